// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core:
// opcodes, function codes, FSM states and instruction field helpers.
package cpu_pkg;

  typedef logic [31:0] inst_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  function automatic logic [5:0] op_of(inst_t i);
    return i[31:26];
  endfunction

  function automatic logic [4:0] rs_of(inst_t i);
    return i[25:21];
  endfunction

  function automatic logic [4:0] rt_of(inst_t i);
    return i[20:16];
  endfunction

  function automatic logic [4:0] rd_of(inst_t i);
    return i[15:11];
  endfunction

  function automatic logic [4:0] sh_of(inst_t i);
    return i[10:6];
  endfunction

  function automatic logic [5:0] fn_of(inst_t i);
    return i[5:0];
  endfunction

  function automatic logic [15:0] imm_of(inst_t i);
    return i[15:0];
  endfunction

  function automatic logic [25:0] addr_of(inst_t i);
    return i[25:0];
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 31x32 register file, two async read ports, one clocked write port.
// Register 0 has no storage and always reads zero.
module cpu_regfile (
  input  logic        clk,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  input  logic        we,
  input  logic [4:0]  wn,
  input  logic [31:0] wd,
  output logic [31:0] qa,
  output logic [31:0] qb
);

  logic [31:0] regs [1:31];

  assign qa = (ra == 5'd0) ? 32'h0 : regs[ra];
  assign qb = (rb == 5'd0) ? 32'h0 : regs[rb];

  always_ff @(posedge clk) begin
    if (we && wn != 5'd0) regs[wn] <= wd;
  end

endmodule

// File: rtl/multi_cycle_cpu_io.sv
// Multi-cycle MIPS-subset CPU on one shared memory/I-O bus with a
// request/ready handshake so slow devices can insert wait states.
module multi_cycle_cpu_io
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter bit          ENABLE_VSHIFT = 1'b1,
  parameter bit          ENABLE_SLT    = 1'b1
) (
  input  logic        clk,
  input  logic        clrn,
  output logic [31:0] m_addr,
  output logic        m_read,
  output logic        m_write,
  output logic        m_fetch,
  input  logic        m_ready,
  input  logic [31:0] d_f_mem,
  output logic [31:0] d_t_mem,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        illegal
);

  state_t      cs, ns, exec_ns;
  inst_t       ir;
  logic [31:0] a, b, alu_reg, mdr;
  logic [31:0] qa, qb, alu_res, pc_exec;
  logic [31:0] pc4, sx, zx, br_t, j_t;
  logic [5:0]  op, fn;
  logic [4:0]  sh, wn;
  logic        rf_we, legal, rt_op;

  assign op    = op_of(ir);
  assign fn    = fn_of(ir);
  assign sh    = sh_of(ir);
  assign rt_op = (op == OP_RTYPE);
  assign pc4   = pc + 32'd4;
  assign sx    = {{16{ir[15]}}, imm_of(ir)};
  assign zx    = {16'h0, imm_of(ir)};
  assign br_t  = pc4 + {sx[29:0], 2'b00};
  assign j_t   = {pc4[31:28], addr_of(ir), 2'b00};
  assign state = cs;

  logic i_add, i_sub, i_and, i_or, i_xor;
  logic i_sll, i_srl, i_sra, i_sllv, i_srlv, i_srav;
  logic i_jr, i_slt, i_addi, i_slti, i_andi, i_ori;
  logic i_xori, i_lui, i_lw, i_sw, i_beq, i_bne;
  logic i_j, i_jal;

  assign i_add  = rt_op && fn == FN_ADD;
  assign i_sub  = rt_op && fn == FN_SUB;
  assign i_and  = rt_op && fn == FN_AND;
  assign i_or   = rt_op && fn == FN_OR;
  assign i_xor  = rt_op && fn == FN_XOR;
  assign i_sll  = rt_op && fn == FN_SLL;
  assign i_srl  = rt_op && fn == FN_SRL;
  assign i_sra  = rt_op && fn == FN_SRA;
  assign i_jr   = rt_op && fn == FN_JR;
  assign i_sllv = ENABLE_VSHIFT && rt_op && fn == FN_SLLV;
  assign i_srlv = ENABLE_VSHIFT && rt_op && fn == FN_SRLV;
  assign i_srav = ENABLE_VSHIFT && rt_op && fn == FN_SRAV;
  assign i_slt  = ENABLE_SLT && rt_op && fn == FN_SLT;
  assign i_slti = ENABLE_SLT && op == OP_SLTI;
  assign i_addi = op == OP_ADDI;
  assign i_andi = op == OP_ANDI;
  assign i_ori  = op == OP_ORI;
  assign i_xori = op == OP_XORI;
  assign i_lui  = op == OP_LUI;
  assign i_lw   = op == OP_LW;
  assign i_sw   = op == OP_SW;
  assign i_beq  = op == OP_BEQ;
  assign i_bne  = op == OP_BNE;
  assign i_j    = op == OP_J;
  assign i_jal  = op == OP_JAL;

  // jal links through alu_reg, computed from pc before it moves.
  always_comb begin
    alu_res = 32'h0;
    pc_exec = pc4;
    exec_ns = S_WB;
    legal   = 1'b1;
    unique case (1'b1)
      i_add:  alu_res = a + b;
      i_sub:  alu_res = a - b;
      i_and:  alu_res = a & b;
      i_or:   alu_res = a | b;
      i_xor:  alu_res = a ^ b;
      i_sll:  alu_res = b << sh;
      i_srl:  alu_res = b >> sh;
      i_sra:  alu_res = $signed(b) >>> sh;
      i_sllv: alu_res = b << a[4:0];
      i_srlv: alu_res = b >> a[4:0];
      i_srav: alu_res = $signed(b) >>> a[4:0];
      i_slt:  alu_res = {31'h0, $signed(a) < $signed(b)};
      i_addi: alu_res = a + sx;
      i_slti: alu_res = {31'h0, $signed(a) < $signed(sx)};
      i_andi: alu_res = a & zx;
      i_ori:  alu_res = a | zx;
      i_xori: alu_res = a ^ zx;
      i_lui:  alu_res = {imm_of(ir), 16'h0};
      i_jal: begin
        alu_res = pc4;
        pc_exec = j_t;
      end
      i_lw, i_sw: begin
        alu_res = a + sx;
        pc_exec = pc;
        exec_ns = S_MEM;
      end
      i_beq: begin
        if (a == b) pc_exec = br_t;
        exec_ns = S_FETCH;
      end
      i_bne: begin
        if (a != b) pc_exec = br_t;
        exec_ns = S_FETCH;
      end
      i_j: begin
        pc_exec = j_t;
        exec_ns = S_FETCH;
      end
      i_jr: begin
        pc_exec = a;
        exec_ns = S_FETCH;
      end
      default: begin
        legal   = 1'b0;
        exec_ns = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) cs <= S_FETCH;
    else       cs <= ns;
  end

  always_comb begin
    ns = cs;
    unique case (cs)
      S_FETCH:  if (m_ready) ns = S_DECODE;
      S_DECODE: ns = S_EXEC;
      S_EXEC:   ns = exec_ns;
      S_MEM:    if (m_ready) ns = i_lw ? S_WB : S_FETCH;
      S_WB:     ns = S_FETCH;
      default:  ns = S_FETCH;
    endcase
  end

  // Requests are gated by clrn so a reset drops the bus at once.
  always_comb begin
    m_addr  = 32'h0;
    m_read  = 1'b0;
    m_write = 1'b0;
    m_fetch = 1'b0;
    d_t_mem = 32'h0;
    illegal = 1'b0;
    rf_we   = 1'b0;
    if (clrn) begin
      unique case (cs)
        S_FETCH: begin
          m_addr  = pc;
          m_read  = 1'b1;
          m_fetch = 1'b1;
        end
        S_EXEC: illegal = !legal;
        S_MEM: begin
          m_addr  = alu_reg;
          m_read  = i_lw;
          m_write = i_sw;
          d_t_mem = i_sw ? b : 32'h0;
        end
        S_WB:    rf_we = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pc      <= RESET_PC;
      ir      <= 32'h0;
      a       <= 32'h0;
      b       <= 32'h0;
      alu_reg <= 32'h0;
      mdr     <= 32'h0;
    end else begin
      unique case (cs)
        S_FETCH: if (m_ready) ir <= d_f_mem;
        S_DECODE: begin
          a <= qa;
          b <= qb;
        end
        S_EXEC: begin
          alu_reg <= alu_res;
          pc      <= pc_exec;
        end
        S_MEM: if (m_ready) begin
          pc <= pc4;
          if (i_lw) mdr <= d_f_mem;
        end
        default: ;
      endcase
    end
  end

  assign wn = i_jal ? 5'd31 : (rt_op ? rd_of(ir) : rt_of(ir));

  cpu_regfile u_rf (
    .clk (clk),
    .ra  (rs_of(ir)),
    .rb  (rt_of(ir)),
    .we  (rf_we),
    .wn  (wn),
    .wd  (i_lw ? mdr : alu_reg),
    .qa  (qa),
    .qb  (qb)
  );

endmodule

// File: tb/tb_multi_cycle_cpu_io.sv
// Directed bench for multi_cycle_cpu_io: two cores (default and
// RESET_PC=0x200 with vshift/slt disabled) on a wait-state memory model.
module tb_multi_cycle_cpu_io;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clrn    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] d_f_mem [2];
  logic [31:0] d_t_mem [2];
  logic [31:0] pc      [2];
  logic        m_read  [2];
  logic        m_write [2];
  logic        m_fetch [2];
  logic        m_ready [2];
  logic        illegal [2];
  logic [2:0]  state   [2];
  int          wait_n  [2];
  int          cnt     [2];
  logic [31:0] mem     [1024];

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t sbq[$];
  int  n_cmp = 0;
  int  n_fail = 0;

  multi_cycle_cpu_io u0 (
    .clk(clk), .clrn(clrn[0]), .m_addr(m_addr[0]),
    .m_read(m_read[0]), .m_write(m_write[0]),
    .m_fetch(m_fetch[0]), .m_ready(m_ready[0]),
    .d_f_mem(d_f_mem[0]), .d_t_mem(d_t_mem[0]),
    .pc(pc[0]), .state(state[0]), .illegal(illegal[0])
  );

  multi_cycle_cpu_io #(
    .RESET_PC(32'h0000_0200),
    .ENABLE_VSHIFT(1'b0),
    .ENABLE_SLT(1'b0)
  ) u1 (
    .clk(clk), .clrn(clrn[1]), .m_addr(m_addr[1]),
    .m_read(m_read[1]), .m_write(m_write[1]),
    .m_fetch(m_fetch[1]), .m_ready(m_ready[1]),
    .d_f_mem(d_f_mem[1]), .d_t_mem(d_t_mem[1]),
    .pc(pc[1]), .state(state[1]), .illegal(illegal[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_bus
    assign m_ready[g] = (m_read[g] || m_write[g])
                        && (cnt[g] >= wait_n[g]);
    assign d_f_mem[g] = mem[m_addr[g][11:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input int id, input logic [31:0] a,
                        input logic [31:0] d);
    wr_t e;
    n_cmp++;
    assert (sbq.size() != 0) else begin
      n_fail++;
      $error("FAIL unexp_wr: cpu%0d wrote %h to %h, want no write",
             id, d, a);
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("wr_id", id, e.id);
      chk("wr_addr", a, e.a);
      chk("wr_data", d, e.d);
    end
  endtask

  // Wait-state memory: ready after wait_n idle request cycles.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!clrn[g] || !(m_read[g] || m_write[g]) || m_ready[g])
        cnt[g] <= 0;
      else
        cnt[g] <= cnt[g] + 1;
      if (clrn[g] && m_write[g] && m_ready[g]) begin
        mem[m_addr[g][11:2]] <= d_t_mem[g];
        sb_pop(g, m_addr[g], d_t_mem[g]);
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs,
    input logic [4:0] rt, input logic [4:0] rd,
    input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op,
    input logic [25:0] ad);
    return {op, ad};
  endfunction

  task automatic ld(input logic [31:0] ad, input logic [31:0] w);
    mem[ad[11:2]] = w;
  endtask

  task automatic expect_wr(input int id, input logic [31:0] ad,
                           input logic [31:0] d);
    wr_t e;
    e.id = id;
    e.a  = ad;
    e.d  = d;
    sbq.push_back(e);
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sbq.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain", sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clrn[0] = 1'b1;
    clrn[1] = 1'b1;
    wait_n[0] = 0;
    wait_n[1] = 3;
    clr_mem();
    #2;
    clrn[0] = 1'b0;
    clrn[1] = 1'b0;
    #1;
    chk("rst_pc0", pc[0], 32'h0);
    chk("rst_pc1", pc[1], 32'h200);
    chk("rst_state", 32'(state[0]), 32'd0);
    chk("rst_read", 32'(m_read[0]), 32'd0);
    chk("rst_illegal", 32'(illegal[0]), 32'd0);

    // Program A: arithmetic, load/store, branch, zero waits.
    ld(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    ld(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'hfffd));
    ld(32'h08, enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
    ld(32'h0c, enc_i(6'h2b, 5'd0, 5'd3, 16'h0040));
    ld(32'h10, enc_i(6'h23, 5'd0, 5'd4, 16'h0040));
    ld(32'h14, enc_i(6'h2b, 5'd0, 5'd4, 16'h0044));
    ld(32'h18, enc_i(6'h0f, 5'd0, 5'd5, 16'h1234));
    ld(32'h1c, enc_i(6'h0d, 5'd5, 5'd5, 16'h8765));
    ld(32'h20, enc_i(6'h0e, 5'd5, 5'd6, 16'hffff));
    ld(32'h24, enc_r(5'd1, 5'd2, 5'd7, 5'd0, 6'h22));
    ld(32'h28, enc_r(5'd0, 5'd2, 5'd8, 5'd1, 6'h03));
    ld(32'h2c, enc_i(6'h0a, 5'd2, 5'd9, 16'hfffe));
    ld(32'h30, enc_i(6'h05, 5'd1, 5'd2, 16'd1));
    ld(32'h34, enc_i(6'h2b, 5'd0, 5'd0, 16'h007c));
    ld(32'h38, enc_i(6'h2b, 5'd0, 5'd5, 16'h0300));
    ld(32'h3c, enc_j(6'h02, 26'h20));
    ld(32'h80, enc_i(6'h2b, 5'd0, 5'd6, 16'h0304));
    ld(32'h84, enc_i(6'h2b, 5'd0, 5'd7, 16'h0308));
    ld(32'h88, enc_i(6'h2b, 5'd0, 5'd8, 16'h030c));
    ld(32'h8c, enc_i(6'h2b, 5'd0, 5'd9, 16'h0310));
    ld(32'h90, enc_r(5'd0, 5'd2, 5'd10, 5'd28, 6'h02));
    ld(32'h94, enc_r(5'd0, 5'd1, 5'd11, 5'd4, 6'h00));
    ld(32'h98, enc_i(6'h2b, 5'd0, 5'd10, 16'h0314));
    ld(32'h9c, enc_i(6'h2b, 5'd0, 5'd11, 16'h0318));
    ld(32'ha0, enc_i(6'h04, 5'd0, 5'd0, 16'hffff));
    expect_wr(0, 32'h40, 32'd2);
    expect_wr(0, 32'h44, 32'd2);
    expect_wr(0, 32'h300, 32'h1234_8765);
    expect_wr(0, 32'h304, 32'h1234_789a);
    expect_wr(0, 32'h308, 32'd8);
    expect_wr(0, 32'h30c, 32'hffff_fffe);
    expect_wr(0, 32'h310, 32'd1);
    expect_wr(0, 32'h314, 32'h0000_000f);
    expect_wr(0, 32'h318, 32'h0000_0050);

    @(negedge clk);
    clrn[0] = 1'b1;
    #1;
    chk("a_fetch_read", 32'(m_read[0]), 32'd1);
    chk("a_fetch_flag", 32'(m_fetch[0]), 32'd1);
    chk("a_fetch_addr", m_addr[0], 32'h0);
    cyc(4);
    chk("a_pc_4cyc", pc[0], 32'h4);
    chk("a_state_4cyc", 32'(state[0]), 32'd0);
    cyc(17);
    chk("a_pc_21cyc", pc[0], 32'h14);
    chk("a_state_21cyc", 32'(state[0]), 32'd0);
    drain(400);
    cyc(7);
    chk("a_loop_pc", pc[0], 32'ha0);
    cyc(3);
    chk("a_loop_pc2", pc[0], 32'ha0);

    // Program B: j / jal / jr, illegal word, srav and slt.
    @(negedge clk);
    clrn[0] = 1'b0;
    clr_mem();
    ld(32'h00, enc_j(6'h02, 26'h8));
    ld(32'h20, enc_j(6'h03, 26'h40));
    ld(32'h100, enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));
    ld(32'h24, enc_i(6'h2b, 5'd0, 5'd31, 16'h0080));
    ld(32'h28, 32'hfc00_0000);
    ld(32'h2c, enc_i(6'h08, 5'd0, 5'd5, 16'hfff0));
    ld(32'h30, enc_i(6'h08, 5'd0, 5'd6, 16'd2));
    ld(32'h34, enc_r(5'd6, 5'd5, 5'd7, 5'd0, 6'h07));
    ld(32'h38, enc_r(5'd5, 5'd6, 5'd8, 5'd0, 6'h2a));
    ld(32'h3c, enc_i(6'h2b, 5'd0, 5'd7, 16'h0084));
    ld(32'h40, enc_i(6'h2b, 5'd0, 5'd8, 16'h0088));
    ld(32'h44, enc_i(6'h04, 5'd0, 5'd0, 16'hffff));
    expect_wr(0, 32'h80, 32'h24);
    expect_wr(0, 32'h84, 32'hffff_fffc);
    expect_wr(0, 32'h88, 32'd1);
    @(negedge clk);
    clrn[0] = 1'b1;
    cyc(3);
    chk("b_pc_j", pc[0], 32'h20);
    cyc(4);
    chk("b_pc_jal", pc[0], 32'h100);
    cyc(3);
    chk("b_pc_jr", pc[0], 32'h24);
    cyc(4);
    chk("b_pc_sw", pc[0], 32'h28);
    cyc(2);
    chk("b_illegal_on", 32'(illegal[0]), 32'd1);
    chk("b_ill_state", 32'(state[0]), 32'd2);
    chk("b_ill_pc", pc[0], 32'h28);
    cyc(1);
    chk("b_illegal_off", 32'(illegal[0]), 32'd0);
    chk("b_ill_pc4", pc[0], 32'h2c);
    chk("b_ill_next", 32'(state[0]), 32'd0);
    drain(200);
    cyc(6);
    chk("b_loop_pc", pc[0], 32'h44);

    // Program C: 3 wait states per access, then reset mid-MEM.
    @(negedge clk);
    clrn[0] = 1'b0;
    clr_mem();
    ld(32'h40, 32'hcafe_babe);
    ld(32'h60, 32'h1111_1111);
    ld(32'h200, enc_i(6'h23, 5'd0, 5'd4, 16'h0040));
    ld(32'h204, enc_i(6'h2b, 5'd0, 5'd4, 16'h0050));
    ld(32'h208, enc_r(5'd6, 5'd5, 5'd7, 5'd0, 6'h07));
    ld(32'h20c, enc_r(5'd0, 5'd0, 5'd8, 5'd0, 6'h2a));
    ld(32'h210, enc_i(6'h23, 5'd0, 5'd4, 16'h0060));
    expect_wr(1, 32'h50, 32'hcafe_babe);
    @(negedge clk);
    clrn[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("c_fwait_addr", m_addr[1], 32'h200);
      chk("c_fwait_read", 32'(m_read[1]), 32'd1);
      chk("c_fwait_state", 32'(state[1]), 32'd0);
    end
    cyc(1);
    chk("c_decode", 32'(state[1]), 32'd1);
    cyc(2);
    for (int i = 0; i < 4; i++) begin
      chk("c_mem_state", 32'(state[1]), 32'd3);
      chk("c_mem_addr", m_addr[1], 32'h40);
      chk("c_mem_read", 32'(m_read[1]), 32'd1);
      chk("c_mem_fetch", 32'(m_fetch[1]), 32'd0);
      if (i < 3) cyc(1);
    end
    cyc(2);
    chk("c_lw_pc", pc[1], 32'h204);
    chk("c_lw_done", 32'(state[1]), 32'd0);
    cyc(10);
    chk("c_sw_pc", pc[1], 32'h208);
    cyc(5);
    chk("c_srav_ill", 32'(illegal[1]), 32'd1);
    cyc(1);
    chk("c_srav_off", 32'(illegal[1]), 32'd0);
    chk("c_srav_pc", pc[1], 32'h20c);
    cyc(5);
    chk("c_slt_ill", 32'(illegal[1]), 32'd1);
    cyc(1);
    chk("c_slt_pc", pc[1], 32'h210);
    cyc(8);
    chk("c_mid_mem", 32'(state[1]), 32'd3);
    chk("c_mid_addr", m_addr[1], 32'h60);
    @(negedge clk);
    clrn[1] = 1'b0;
    #1;
    chk("c_rst_pc", pc[1], 32'h200);
    chk("c_rst_state", 32'(state[1]), 32'd0);
    chk("c_rst_read", 32'(m_read[1]), 32'd0);
    chk("c_rst_write", 32'(m_write[1]), 32'd0);
    ld(32'h200, enc_i(6'h2b, 5'd0, 5'd4, 16'h0054));
    expect_wr(1, 32'h54, 32'hcafe_babe);
    @(negedge clk);
    clrn[1] = 1'b1;
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_fail);
    $finish;
  end

endmodule
